// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding Wishbone classic initiator with response timeout
module wb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  input  logic        err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          adr_d   = req_addr;
          dat_d   = req_wdata;
          we_d    = req_we;
          sel_d   = req_sel;
          cnt_d   = 8'd0;
          state_d = BUS;
        end
      end
      BUS: begin
        // err_i has priority so a confused slave raising both reports an error
        if (err_i) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (ack_i) begin
          rdata_d = we_q ? 32'd0 : dat_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and strobe outputs decode state only; no input reaches an output combinationally
  assign req_ready = (state_q == IDLE);
  assign cyc_o     = (state_q == BUS);
  assign stb_o     = (state_q == BUS);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - directed self-checking bench for wb_initiator
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;
  logic        err_i;

  int errors = 0;
  int checks = 0;
  int ncyc;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .err_i(err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the slave side while the cycle is open; n counts cycles with cyc_o high
  task automatic finish_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                            input logic [3:0] sel, input int dly, input logic a, input logic e,
                            input logic [31:0] rd, input logic hold, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!cyc_o) break;
      n++;
      check("stb", stb_o, 1);
      check("adr", adr_o, addr);
      check("dat", dat_o, wdata);
      check("we", we_o, we);
      check("sel", sel_o, sel);
      if (n == dly + 1) begin
        ack_i = a; err_i = e; dat_i = rd;
      end else begin
        ack_i = 1'b0; err_i = 1'b0; dat_i = 32'hBAD0_BAD0;
      end
      tick();
    end
    if (!hold) begin
      ack_i = 1'b0; err_i = 1'b0;
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                           input logic [3:0] sel);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we; req_sel = sel;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [3:0] sel, input int dly, input logic a, input logic e,
                         input logic [31:0] rd, input logic hold, output int n);
    start_req(addr, wdata, we, sel);
    finish_txn(addr, wdata, we, sel, dly, a, e, rd, hold, n);
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_rdata"}, rsp_rdata, rdata);
    check({tag, "_err"}, rsp_err, err);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("consume_valid", rsp_valid, 0);
    check("consume_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    tick(); tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_we", we_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", req_ready, 1);

    // Write acked after one wait state
    run_txn(32'h0000_0002, 32'h0000_0001, 1'b1, 4'hF, 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, ncyc);
    check("wr_cyc_len", ncyc, 2);
    expect_rsp("wr", 32'h0, 1'b0);
    consume();

    // Zero-wait read with ack held afterwards
    run_txn(32'h0000_0010, 32'h0, 1'b0, 4'hF, 0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, ncyc);
    check("rd_cyc_len", ncyc, 1);
    expect_rsp("rd", 32'h0000_0001, 1'b0);
    consume();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_ack_no_rsp", rsp_valid, 0);
      check("held_ack_no_cyc", cyc_o, 0);
    end
    ack_i = 1'b0;

    // Timeout with silent slave
    run_txn(32'h0000_0100, 32'h0, 1'b0, 4'h3, 1000, 1'b0, 1'b0, 32'h0, 1'b0, ncyc);
    check("to_cyc_len", ncyc, 16);
    expect_rsp("to", 32'h0, 1'b1);
    consume();

    // ack and err together, then a clean read
    run_txn(32'h0000_0200, 32'h0, 1'b0, 4'hF, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, ncyc);
    check("both_cyc_len", ncyc, 1);
    expect_rsp("both", 32'h0, 1'b1);
    consume();
    run_txn(32'h0000_0204, 32'h0, 1'b0, 4'hF, 2, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, ncyc);
    check("a5_cyc_len", ncyc, 3);
    expect_rsp("a5", 32'hA5A5_A5A5, 1'b0);
    consume();

    // Backpressure with a waiting request
    run_txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, ncyc);
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h0000_00C3; req_we = 1'b1;
    req_sel = 4'h1;
    for (int i = 0; i < 5; i++) begin
      expect_rsp("bp", 32'h1234_5678, 1'b0);
      check("bp_req_ready", req_ready, 0);
      check("bp_cyc", cyc_o, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rel_ready", req_ready, 1);
    check("bp_rel_cyc", cyc_o, 0);
    tick();
    req_valid = 1'b0;
    check("bp_start_cyc", cyc_o, 1);
    finish_txn(32'h0000_0040, 32'h0000_00C3, 1'b1, 4'h1, 0, 1'b1, 1'b0, 32'h7777_7777, 1'b0, ncyc);
    check("bp_cyc_len", ncyc, 1);
    expect_rsp("bp_wr", 32'h0, 1'b0);
    consume();

    // Reset two cycles into a read
    start_req(32'h0000_0500, 32'h0000_0055, 1'b0, 4'hC);
    tick();
    tick();
    check("mid_cyc_before", cyc_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_cyc", cyc_o, 0);
    check("mid_stb", stb_o, 0);
    check("mid_adr", adr_o, 0);
    check("mid_dat", dat_o, 0);
    check("mid_sel", sel_o, 0);
    check("mid_we", we_o, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_rdata", rsp_rdata, 0);
    check("mid_err", rsp_err, 0);
    check("mid_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_rsp", rsp_valid, 0);
    end
    run_txn(32'h0000_0600, 32'h0, 1'b0, 4'hF, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, ncyc);
    check("post_cyc_len", ncyc, 2);
    expect_rsp("post", 32'hCAFE_F00D, 1'b0);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
